vga_timing_gen: RTL

//  Upstream stage of the pixel pipeline: free-running 640x480@60 VGA raster timing generator on the 25 MHz board clock.

---
 rtl/vga_timing_pkg.sv | 64 ++++++
 rtl/mod_counter.sv | 36 +++
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster constants for the pixel pipeline. Holds the 640x480@60
// default geometry, the resulting line/frame totals, and the start offsets of
// the visible window (H_ACT_START = 144, V_ACT_START = 35) that the background
// and sprite layers rely on. Also provides the region decode used by the
// timing generator.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

   // Default 640x480@60 geometry (25 MHz pixel clock).
   localparam int H_ACTIVE_DEF  = 640;
   localparam int H_FP_DEF      = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BP_DEF      = 48;
   localparam int V_ACTIVE_DEF  = 480;
   localparam int V_FP_DEF      = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BP_DEF      = 33;
   localparam int FRAME_W_DEF   = 8;
   localparam int SYNC_DLY_DEF  = 2;

   // Width of h_count/v_count; 10 bits covers 0..799 and 0..524.
   localparam int CNT_W         = 10;

   localparam int H_TOTAL       = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
   localparam int V_TOTAL       = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

   // Lines are ordered sync, back porch, active, front porch, so the visible
   // window starts right after sync + back porch on both axes.
   localparam int H_ACT_START   = H_SYNC_DEF + H_BP_DEF;
   localparam int V_ACT_START   = V_SYNC_DEF + V_BP_DEF;

   typedef enum logic [1:0] {
      SEG_SYNC,
      SEG_BACK,
      SEG_ACTIVE,
      SEG_FRONT
   } seg_e;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
      logic line_start;
      logic frame_start;
   } timing_flags_t;

   // Classifies a position along one axis into its raster segment.
   function automatic seg_e segment_of(input int pos, input int sync_len,
                                       input int bp_len, input int act_len);
      seg_e seg;
      if (pos < sync_len)
         seg = SEG_SYNC;
      else if (pos < sync_len + bp_len)
         seg = SEG_BACK;
      else if (pos < sync_len + bp_len + act_len)
         seg = SEG_ACTIVE;
      else
         seg = SEG_FRONT;
      return seg;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Modulo-N up counter with enable and synchronous active-high reset.
//   clk   : clock
//   rst   : synchronous reset, clears count to 0
//   en    : advance enable
//   count : current value, 0..N-1
//   wrap  : high while count sits on its terminal value N-1 (not gated by en),
//           so the next enabled edge returns count to 0
// ---------------------------------------------------------------------------
module mod_counter
   import vga_timing_pkg::*;
#(
   parameter int N = H_TOTAL,
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   assign wrap = (count == LAST);

   // Counts 0..N-1 and rolls over to 0 on the enabled edge after the last value.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (en)
         count <= wrap ? '0 : count + W'(1);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Free-running VGA raster timing generator (640x480@60 by default). Drives
// the pixel position consumed by the layer modules plus sync, visible-area,
// line/frame pulses and a frame counter used to pace animation.
//   clk         : pixel clock (25 MHz)
//   rst         : synchronous active-high reset
//   pix_en      : pixel advance enable; everything holds while low and the
//                 line/frame pulses are forced to 0
//   h_count     : horizontal position 0..H_TOTAL-1
//   v_count     : vertical position 0..V_TOTAL-1
//   hsync/vsync : active-low sync
//   active      : pixel is inside the visible window
//   line_start  : one-cycle pulse when h_count becomes 0
//   frame_start : one-cycle pulse when h_count and v_count both become 0
//   frame_cnt   : frames completed since reset, wrapping
// Build option: define VGA_TIMING_SYNC_DLY_EN to pass hsync/vsync through a
// SYNC_DLY-deep shift register (advancing on pix_en) so sync lines up with a
// registered colour path downstream. Without it, SYNC_DLY is ignored.
// ---------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int FRAME_W  = FRAME_W_DEF,
   parameter int SYNC_DLY = SYNC_DLY_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
   output logic [CNT_W-1:0]   h_count,
   output logic [CNT_W-1:0]   v_count,
   output logic               hsync,
   output logic               vsync,
   output logic               active,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int LINE_LEN    = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int FRAME_LINES = V_SYNC + V_BP + V_ACTIVE + V_FP;

   logic          h_wrap;
   logic          v_wrap;
   logic          v_en;
   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;
   seg_e          h_seg;
   seg_e          v_seg;
   timing_flags_t flags_nxt;
   timing_flags_t flags_q;

   // The vertical counter only steps on the pixel that closes a line.
   assign v_en = pix_en & h_wrap;

   mod_counter #(.N(LINE_LEN), .W(CNT_W)) u_h_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (pix_en),
      .count (h_count),
      .wrap  (h_wrap)
   );

   mod_counter #(.N(FRAME_LINES), .W(CNT_W)) u_v_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (v_en),
      .count (v_count),
      .wrap  (v_wrap)
   );

   // Decode from the position the counters will hold after the next advance,
   // so the registered flags land in the same cycle as the new counts.
   always_comb begin
      h_nxt = h_wrap ? '0 : h_count + CNT_W'(1);
      v_nxt = v_count;
      if (h_wrap)
         v_nxt = v_wrap ? '0 : v_count + CNT_W'(1);

      h_seg = segment_of(int'(h_nxt), H_SYNC, H_BP, H_ACTIVE);
      v_seg = segment_of(int'(v_nxt), V_SYNC, V_BP, V_ACTIVE);

      flags_nxt.hsync       = (h_seg != SEG_SYNC);
      flags_nxt.vsync       = (v_seg != SEG_SYNC);
      flags_nxt.active      = (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
      flags_nxt.line_start  = (h_nxt == '0);
      flags_nxt.frame_start = (h_nxt == '0) && (v_nxt == '0);
   end

   // Level outputs hold while pix_en is low; the pulses are cleared so a stall
   // on the first pixel of a line can never stretch them. frame_cnt steps on
   // the same edge that raises frame_start, so frame 0 is counted when it ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q   <= '{hsync: 1'b1, vsync: 1'b1, active: 1'b0,
                        line_start: 1'b0, frame_start: 1'b0};
         frame_cnt <= '0;
      end else if (pix_en) begin
         flags_q <= flags_nxt;
         if (flags_nxt.frame_start)
            frame_cnt <= frame_cnt + FRAME_W'(1);
      end else begin
         flags_q.line_start  <= 1'b0;
         flags_q.frame_start <= 1'b0;
      end
   end

   assign active      = flags_q.active;
   assign line_start  = flags_q.line_start;
   assign frame_start = flags_q.frame_start;

`ifdef VGA_TIMING_SYNC_DLY_EN
   logic [SYNC_DLY-1:0] hsync_sr;
   logic [SYNC_DLY-1:0] vsync_sr;

   // Sync delay line: steps only with pixel advance and idles high in reset,
   // so the delayed sync stays aligned to pixels rather than clock cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_sr <= '1;
         vsync_sr <= '1;
      end else if (pix_en) begin
         hsync_sr[0] <= flags_q.hsync;
         vsync_sr[0] <= flags_q.vsync;
         for (int i = 1; i < SYNC_DLY; i++) begin
            hsync_sr[i] <= hsync_sr[i-1];
            vsync_sr[i] <= vsync_sr[i-1];
         end
      end
   end

   assign hsync = hsync_sr[SYNC_DLY-1];
   assign vsync = vsync_sr[SYNC_DLY-1];
`else
   // Sync leaves straight from the decode registers; SYNC_DLY has no effect
   // here and only a non-negative depth is meaningful.
   if (SYNC_DLY >= 0) begin : g_sync_direct
      assign hsync = flags_q.hsync;
      assign vsync = flags_q.vsync;
   end
`endif

endmodule
